// File: rtl/argmax_classifier.sv
// Argmax stage after the output neuron layer: gathers one word per neuron, then scans
// them one compare per cycle and offers the winning index/value on a valid/ready port.
module argmax_classifier #(
    parameter  int nn         = 10,
    parameter  int data_width = 16,
    parameter  bit is_signed  = 1'b0,
    localparam int idx_width  = $clog2(nn)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [nn-1:0]              i_valid,
    input  logic [nn*data_width-1:0]   x_in_flat,
    output logic                       class_valid,
    input  logic                       class_ready,
    output logic [idx_width-1:0]       class_idx,
    output logic [data_width-1:0]      class_val,
    output logic                       o_overrun,
    output logic                       o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [nn-1:0]           got;
    logic [nn-1:0]           got_nx;
    logic [data_width-1:0]   slot [nn];
    logic [idx_width-1:0]    cnt;
    logic [idx_width-1:0]    best_idx;
    logic [data_width-1:0]   best_val;
    logic [data_width-1:0]   cur;
    logic                    gt;
    logic                    take;
    logic                    last;

    // Compare the word under the scan pointer against the running best.
    always_comb begin
        got_nx = got | i_valid;
        cur    = slot[cnt];
        if (is_signed) begin
            gt = $signed(cur) > $signed(best_val);
        end else begin
            gt = cur > best_val;
        end
        take = (cnt == '0) || gt;
        last = (cnt == idx_width'(nn - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (&got_nx)     state_nx = SCAN;
            SCAN:    if (last)        state_nx = DONE;
            DONE:    if (class_ready) state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != IDLE) || (|got);
    end

    // Inputs seen outside IDLE are dropped and only flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            got         <= '0;
            cnt         <= '0;
            best_idx    <= '0;
            best_val    <= '0;
            class_valid <= 1'b0;
            o_overrun   <= 1'b0;
            for (int unsigned i = 0; i < nn; i++) begin
                slot[i] <= '0;
            end
        end else begin
            o_overrun <= (state != IDLE) && (|i_valid);
            case (state)
                IDLE: begin
                    for (int unsigned i = 0; i < nn; i++) begin
                        if (i_valid[i]) begin
                            slot[i] <= x_in_flat[i*data_width +: data_width];
                        end
                    end
                    got <= got_nx;
                    cnt <= '0;
                end
                SCAN: begin
                    if (take) begin
                        best_val <= cur;
                        best_idx <= cnt;
                    end
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        class_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (class_ready) begin
                        class_valid <= 1'b0;
                        got         <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign class_idx = best_idx;
    assign class_val = best_val;

endmodule

// File: tb/tb_argmax_classifier.sv
// Bench for argmax_classifier: unsigned and signed instances share stimulus and are
// checked every cycle against an argmax model, plus hand-computed literal results.
module tb_argmax_classifier;

    localparam int NN = 10;
    localparam int DW = 16;

    typedef logic [DW-1:0] word_t;
    typedef word_t words_t [NN];
    typedef enum {M_COL, M_WAIT, M_PRES} mode_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NN-1:0]     i_valid = '0;
    logic [NN*DW-1:0]  x_in_flat = '0;
    logic              class_ready = 1'b0;

    logic          u_valid, s_valid, u_ovr, s_ovr, u_busy, s_busy;
    logic [3:0]    u_idx, s_idx;
    logic [DW-1:0] u_val, s_val;

    always #5 clk = ~clk;

    argmax_classifier #(.nn(NN), .data_width(DW), .is_signed(1'b0)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .x_in_flat(x_in_flat),
        .class_valid(u_valid), .class_ready(class_ready), .class_idx(u_idx),
        .class_val(u_val), .o_overrun(u_ovr), .o_busy(u_busy)
    );

    argmax_classifier #(.nn(NN), .data_width(DW), .is_signed(1'b1)) dut_s (
        .clk(clk), .rst(rst), .i_valid(i_valid), .x_in_flat(x_in_flat),
        .class_valid(s_valid), .class_ready(class_ready), .class_idx(s_idx),
        .class_val(s_val), .o_overrun(s_ovr), .o_busy(s_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int argmax(input words_t w, input bit sgn);
        int b = 0;
        for (int i = 1; i < NN; i++) begin
            if (sgn ? ($signed(w[i]) > $signed(w[b])) : (w[i] > w[b])) b = i;
        end
        return b;
    endfunction

    function automatic word_t maxval(input words_t w, input bit sgn);
        return w[argmax(w, sgn)];
    endfunction

    function automatic words_t merge(input words_t w, input logic [NN-1:0] v,
                                     input logic [NN*DW-1:0] f);
        words_t r = w;
        for (int i = 0; i < NN; i++) begin
            if (v[i]) r[i] = f[i*DW +: DW];
        end
        return r;
    endfunction

    function automatic logic [NN*DW-1:0] pack(input words_t w);
        logic [NN*DW-1:0] r = '0;
        for (int i = 0; i < NN; i++) r[i*DW +: DW] = w[i];
        return r;
    endfunction

    // Model: collect words, compute the argmax at once, reveal it NN cycles later.
    mode_t         m_mode = M_COL;
    words_t        m_slot = '{default: '0};
    logic [NN-1:0] m_got  = '0;
    int            m_cd   = 0;
    logic          m_ovr  = 1'b0;
    int            e_idx_u = 0, e_idx_s = 0;
    word_t         e_val_u = '0, e_val_s = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode <= M_COL;
            m_slot <= '{default: '0};
            m_got  <= '0;
            m_cd   <= 0;
            m_ovr  <= 1'b0;
        end else begin
            m_ovr <= (m_mode != M_COL) && (|i_valid);
            case (m_mode)
                M_COL: begin
                    m_slot <= merge(m_slot, i_valid, x_in_flat);
                    m_got  <= m_got | i_valid;
                    if (&(m_got | i_valid)) begin
                        e_idx_u <= argmax(merge(m_slot, i_valid, x_in_flat), 1'b0);
                        e_idx_s <= argmax(merge(m_slot, i_valid, x_in_flat), 1'b1);
                        e_val_u <= maxval(merge(m_slot, i_valid, x_in_flat), 1'b0);
                        e_val_s <= maxval(merge(m_slot, i_valid, x_in_flat), 1'b1);
                        m_mode  <= M_WAIT;
                        m_cd    <= NN;
                    end
                end
                M_WAIT: begin
                    m_cd <= m_cd - 1;
                    if (m_cd == 1) m_mode <= M_PRES;
                end
                default: begin
                    if (class_ready) begin
                        m_mode <= M_COL;
                        m_got  <= '0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("valid_u", u_valid, m_mode == M_PRES);
            chk("valid_s", s_valid, m_mode == M_PRES);
            chk("ovr_u", u_ovr, m_ovr);
            chk("ovr_s", s_ovr, m_ovr);
            chk("busy_u", u_busy, (m_mode != M_COL) || (|m_got));
            chk("busy_s", s_busy, (m_mode != M_COL) || (|m_got));
            if (m_mode == M_PRES) begin
                chk("idx_u", u_idx, e_idx_u);
                chk("val_u", u_val, e_val_u);
                chk("idx_s", s_idx, e_idx_s);
                chk("val_s", s_val, e_val_s);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [NN-1:0] v, input words_t w);
        i_valid   = v;
        x_in_flat = pack(w);
        @(negedge clk);
        i_valid = '0;
    endtask

    task automatic accept();
        class_ready = 1'b1;
        cyc(1);
        class_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        words_t w1, ws, w3, wt, wf, junk;
        w1 = '{16'h0100, 16'h0200, 16'h0F00, 16'h0300, 16'h0050,
               16'h0000, 16'h0000, 16'h0000, 16'h0EFF, 16'h0001};
        ws = '{default: 16'h1000};
        ws[7] = 16'h7FFF;
        w3 = ws;
        w3[3] = 16'h8000;
        wt = '{default: 16'h0100};
        wt[4] = 16'h0ABC;
        wt[8] = 16'h0ABC;
        for (int i = 0; i < NN; i++) wf[i] = 16'hFF00 + 16'(i);
        wf[3] = 16'hFFF0;
        wf[9] = 16'h0000;
        junk = '{default: 16'hFFFF};

        cyc(2);
        chk("rst_valid", u_valid, 0);
        chk("rst_idx", u_idx, 0);
        chk("rst_val", u_val, 0);
        chk("rst_busy", u_busy, 0);
        chk("rst_ovr", u_ovr, 0);
        rst = 1'b1;
        cyc(1);

        // Full vector in one edge, latency and hold
        send('1, w1);
        cyc(9);
        chk("t1_not_yet", u_valid, 0);
        cyc(1);
        chk("t1_valid", u_valid, 1);
        chk("t1_idx", u_idx, 2);
        chk("t1_val", u_val, 16'h0F00);
        chk("t1_idx_s", s_idx, 2);
        cyc(5);
        chk("t1_hold", u_valid, 1);
        accept();
        chk("t1_released", u_valid, 0);
        chk("t1_busy", u_busy, 0);

        // Staggered arrival
        send(10'h01F, ws);
        cyc(5);
        send(10'h3E0, ws);
        cyc(9);
        chk("t2_not_yet", u_valid, 0);
        cyc(1);
        chk("t2_idx", u_idx, 7);
        chk("t2_val", u_val, 16'h7FFF);
        accept();

        // Staggered with a last-write-wins resend
        send(10'h01F, ws);
        cyc(2);
        send(10'h008, w3);
        chk("t2b_no_ovr", u_ovr, 0);
        cyc(2);
        send(10'h3E0, w3);
        cyc(10);
        chk("t2b_idx_u", u_idx, 3);
        chk("t2b_val_u", u_val, 16'h8000);
        chk("t2b_idx_s", s_idx, 7);
        accept();

        // Tie keeps the lower index
        send('1, wt);
        cyc(10);
        chk("t3_idx_u", u_idx, 4);
        chk("t3_idx_s", s_idx, 4);
        accept();

        // Signed versus unsigned ordering
        send('1, wf);
        cyc(10);
        chk("t4_idx_u", u_idx, 3);
        chk("t4_val_u", u_val, 16'hFFF0);
        chk("t4_idx_s", s_idx, 9);
        chk("t4_val_s", s_val, 16'h0000);
        accept();

        // Overrun in SCAN, in DONE, and together with the accepting edge
        send('1, w1);
        cyc(3);
        send(10'h001, junk);
        chk("t5_ovr_scan", u_ovr, 1);
        cyc(1);
        chk("t5_ovr_pulse", u_ovr, 0);
        cyc(5);
        chk("t5_idx", u_idx, 2);
        send(10'h001, junk);
        chk("t5_ovr_done", u_ovr, 1);
        chk("t5_idx_kept", u_idx, 2);
        chk("t5_val_kept", u_val, 16'h0F00);
        class_ready = 1'b1;
        i_valid     = 10'h002;
        cyc(1);
        class_ready = 1'b0;
        i_valid     = '0;
        chk("t5_ovr_acc", u_ovr, 1);
        chk("t5_acc_valid", u_valid, 0);
        chk("t5_acc_busy", u_busy, 0);
        send('1, wt);
        cyc(10);
        chk("t5_next_idx", u_idx, 4);
        accept();

        // Asynchronous reset in the middle of a scan
        send('1, w1);
        cyc(5);
        #2 rst = 1'b0;
        #1;
        chk("t6_valid", u_valid, 0);
        chk("t6_idx", u_idx, 0);
        chk("t6_val", u_val, 0);
        chk("t6_busy", u_busy, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc(15);
        chk("t6_no_result", u_valid, 0);
        send('1, wf);
        cyc(10);
        chk("t6_idx_u", u_idx, 3);
        chk("t6_idx_s", s_idx, 9);
        accept();
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
